// File: rtl/uart_block_loader.sv
// Parses framed UART packets (A5, X, Y, Z, TYPE, CHK) into single block-write requests
// toward the L3 cache, counting completed writes and rejected packets.
module uart_block_loader #(
  parameter int LENGTH         = 64,
  parameter int WIDTH          = 64,
  parameter int HEIGHT         = 16,
  parameter int BLOCK_W        = 5,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rx_valid_in,
  input  logic [7:0]                rx_byte_in,
  output logic                      wr_valid_out,
  input  logic                      wr_ready_in,
  output logic [$clog2(LENGTH)-1:0] wr_x_out,
  output logic [$clog2(WIDTH)-1:0]  wr_y_out,
  output logic [$clog2(HEIGHT)-1:0] wr_z_out,
  output logic [BLOCK_W-1:0]        wr_block_out,
  output logic                      busy_out,
  output logic [7:0]                err_count_out,
  output logic [15:0]               pkt_count_out
);

  localparam int XW = $clog2(LENGTH);
  localparam int YW = $clog2(WIDTH);
  localparam int ZW = $clog2(HEIGHT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [31:0] X_LIM = 32'(LENGTH);
  localparam logic [31:0] Y_LIM = 32'(WIDTH);
  localparam logic [31:0] Z_LIM = 32'(HEIGHT);
  localparam logic [31:0] T_LIM = 32'd1 << BLOCK_W;

  // GET_X..GET_CHK are consecutive so a data byte simply advances the state by one.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_X   = 3'd1;
  localparam logic [2:0] S_GET_Y   = 3'd2;
  localparam logic [2:0] S_GET_Z   = 3'd3;
  localparam logic [2:0] S_GET_T   = 3'd4;
  localparam logic [2:0] S_GET_CHK = 3'd5;
  localparam logic [2:0] S_EMIT    = 3'd6;

  localparam logic [7:0] SYNC = 8'hA5;

  logic [2:0]    r_state;
  logic [7:0]    r_x, r_y, r_z, r_t;
  logic [TW-1:0] r_tmo;
  logic          r_wr_valid;
  logic [XW-1:0] r_wr_x;
  logic [YW-1:0] r_wr_y;
  logic [ZW-1:0] r_wr_z;
  logic [BLOCK_W-1:0] r_wr_block;
  logic [7:0]    r_err;
  logic [15:0]   r_pkt;

  logic w_in_get, w_tmo_hit, w_fields_ok, w_chk_ok, w_accept, w_handshake, w_err_inc;

  assign w_in_get    = (r_state >= S_GET_X) && (r_state <= S_GET_CHK);
  assign w_tmo_hit   = w_in_get && !rx_valid_in && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_fields_ok = (32'(r_x) < X_LIM) && (32'(r_y) < Y_LIM) &&
                       (32'(r_z) < Z_LIM) && (32'(r_t) < T_LIM);
  assign w_chk_ok    = (rx_byte_in == (r_x ^ r_y ^ r_z ^ r_t)) && w_fields_ok;
  assign w_accept    = (r_state == S_GET_CHK) && rx_valid_in && w_chk_ok;
  assign w_handshake = r_wr_valid && wr_ready_in;
  // Bad packet, idle timeout and overrun are mutually exclusive by state, so one +1 at most.
  assign w_err_inc   = ((r_state == S_GET_CHK) && rx_valid_in && !w_chk_ok) ||
                       w_tmo_hit ||
                       ((r_state == S_EMIT) && rx_valid_in);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (rx_valid_in && (rx_byte_in == SYNC)) r_state <= S_GET_X;
        end
        S_GET_X, S_GET_Y, S_GET_Z, S_GET_T, S_GET_CHK: begin
          if (rx_valid_in) begin
            r_tmo <= '0;
            if (r_state != S_GET_CHK) r_state <= r_state + 3'd1;
            else                      r_state <= w_chk_ok ? S_EMIT : S_IDLE;
          end else if (w_tmo_hit) begin
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_EMIT: begin
          if (w_handshake) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
      r_t <= '0;
    end else if (rx_valid_in) begin
      case (r_state)
        S_GET_X: r_x <= rx_byte_in;
        S_GET_Y: r_y <= rx_byte_in;
        S_GET_Z: r_z <= rx_byte_in;
        S_GET_T: r_t <= rx_byte_in;
        default: ;
      endcase
    end
  end

  // Write fields are loaded only on acceptance, so they stay frozen for the whole EMIT phase.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_valid <= 1'b0;
      r_wr_x     <= '0;
      r_wr_y     <= '0;
      r_wr_z     <= '0;
      r_wr_block <= '0;
    end else if (w_accept) begin
      r_wr_valid <= 1'b1;
      r_wr_x     <= XW'(r_x);
      r_wr_y     <= YW'(r_y);
      r_wr_z     <= ZW'(r_z);
      r_wr_block <= BLOCK_W'(r_t);
    end else if (w_handshake) begin
      r_wr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_err <= '0;
      r_pkt <= '0;
    end else begin
      if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
      if (w_handshake)                   r_pkt <= r_pkt + 16'd1;
    end
  end

  assign wr_valid_out  = r_wr_valid;
  assign wr_x_out      = r_wr_x;
  assign wr_y_out      = r_wr_y;
  assign wr_z_out      = r_wr_z;
  assign wr_block_out  = r_wr_block;
  assign busy_out      = (r_state != S_IDLE);
  assign err_count_out = r_err;
  assign pkt_count_out = r_pkt;

endmodule

// File: tb/tb_uart_block_loader.sv
// Directed bench for uart_block_loader: a packet-level reference model is stepped every
// clock and compared against all outputs, with hand-computed literal checks per scenario.
module tb_uart_block_loader;

  localparam int LEN = 64;
  localparam int WID = 64;
  localparam int HGT = 16;
  localparam int BW  = 5;
  localparam int TMO = 40;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rx_valid_in = 1'b0;
  logic [7:0]  rx_byte_in = 8'h00;
  logic        wr_ready_in = 1'b1;
  logic        wr_valid_out;
  logic [5:0]  wr_x_out;
  logic [5:0]  wr_y_out;
  logic [3:0]  wr_z_out;
  logic [4:0]  wr_block_out;
  logic        busy_out;
  logic [7:0]  err_count_out;
  logic [15:0] pkt_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  uart_block_loader #(
    .LENGTH(LEN), .WIDTH(WID), .HEIGHT(HGT), .BLOCK_W(BW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_valid_in(rx_valid_in), .rx_byte_in(rx_byte_in),
    .wr_valid_out(wr_valid_out), .wr_ready_in(wr_ready_in),
    .wr_x_out(wr_x_out), .wr_y_out(wr_y_out), .wr_z_out(wr_z_out),
    .wr_block_out(wr_block_out), .busy_out(busy_out),
    .err_count_out(err_count_out), .pkt_count_out(pkt_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: bytes collected so far in the current packet, idle gap, pending write.
  int         m_idx;
  logic [7:0] m_b [4];
  int         m_idle;
  bit         m_pend;
  int         m_wx, m_wy, m_wz, m_wt;
  int         m_err, m_pkt;

  task automatic model_reset();
    m_idx = 0; m_idle = 0; m_pend = 0;
    m_wx = 0; m_wy = 0; m_wz = 0; m_wt = 0;
    m_err = 0; m_pkt = 0;
    for (int i = 0; i < 4; i++) m_b[i] = 8'h00;
  endtask

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step();
    if (!rst_in) begin
      model_reset();
    end else if (m_pend) begin
      if (wr_ready_in) begin
        m_pend = 0;
        m_pkt  = (m_pkt + 1) % 65536;
      end
      if (rx_valid_in) bump_err();
    end else if (m_idx == 0) begin
      if (rx_valid_in && rx_byte_in == 8'hA5) begin
        m_idx = 1; m_idle = 0;
      end
    end else if (rx_valid_in) begin
      m_idle = 0;
      if (m_idx < 5) begin
        m_b[m_idx-1] = rx_byte_in;
        m_idx++;
      end else begin
        m_idx = 0;
        if (rx_byte_in == (m_b[0] ^ m_b[1] ^ m_b[2] ^ m_b[3]) &&
            m_b[0] < LEN && m_b[1] < WID && m_b[2] < HGT && m_b[3] < (1 << BW)) begin
          m_pend = 1;
          m_wx = m_b[0]; m_wy = m_b[1]; m_wz = m_b[2]; m_wt = m_b[3];
        end else begin
          bump_err();
        end
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        m_idx = 0; m_idle = 0;
        bump_err();
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("m_valid", 32'(wr_valid_out), 32'(m_pend));
    check("m_x",     32'(wr_x_out), m_wx);
    check("m_y",     32'(wr_y_out), m_wy);
    check("m_z",     32'(wr_z_out), m_wz);
    check("m_block", 32'(wr_block_out), m_wt);
    check("m_busy",  32'(busy_out), 32'(m_pend || m_idx != 0));
    check("m_err",   32'(err_count_out), m_err);
    check("m_pkt",   32'(pkt_count_out), m_pkt);
  endtask

  // One clock: model sees the inputs the DUT samples, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid_in = 1'b1;
    rx_byte_in  = b;
    tick();
    rx_valid_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                          input logic [7:0] t, input logic [7:0] c);
    send_byte(8'hA5); send_byte(x); send_byte(y); send_byte(z); send_byte(t); send_byte(c);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_valid", 32'(wr_valid_out), 0);
    check("rst_busy",  32'(busy_out), 0);
    check("rst_err",   32'(err_count_out), 0);
    check("rst_pkt",   32'(pkt_count_out), 0);
    idle(2);
    rst_in = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Basic write with ready held high
    wr_ready_in = 1'b1;
    send_pkt(8'h03, 8'h05, 8'h02, 8'h07, 8'h03);
    check("ok_valid", 32'(wr_valid_out), 1);
    check("ok_x", 32'(wr_x_out), 3);
    check("ok_y", 32'(wr_y_out), 5);
    check("ok_z", 32'(wr_z_out), 2);
    check("ok_blk", 32'(wr_block_out), 7);
    tick();
    check("ok_valid_drop", 32'(wr_valid_out), 0);
    check("ok_pkt", 32'(pkt_count_out), 1);
    check("ok_busy", 32'(busy_out), 0);

    // Bad checksum
    do_reset();
    send_pkt(8'h03, 8'h05, 8'h02, 8'h07, 8'h04);
    check("chk_valid", 32'(wr_valid_out), 0);
    check("chk_err", 32'(err_count_out), 1);
    check("chk_busy", 32'(busy_out), 0);
    tick();

    // Range rejects, extreme legal values, A5 inside a packet
    do_reset();
    send_pkt(8'h00, 8'h00, 8'h10, 8'h01, 8'h11);
    check("z_rng_err", 32'(err_count_out), 1);
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    check("after_rng_valid", 32'(wr_valid_out), 1);
    check("after_rng_z", 32'(wr_z_out), 3);
    tick();
    check("after_rng_pkt", 32'(pkt_count_out), 1);
    send_pkt(8'h3F, 8'h3F, 8'h0F, 8'h1F, 8'h10);
    check("max_x", 32'(wr_x_out), 63);
    check("max_blk", 32'(wr_block_out), 31);
    tick();
    send_pkt(8'h00, 8'h00, 8'h00, 8'h20, 8'h20);
    check("t_rng_err", 32'(err_count_out), 2);
    send_pkt(8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5);
    check("a5_data_err", 32'(err_count_out), 3);
    check("a5_data_busy", 32'(busy_out), 0);
    send_pkt(8'h40, 8'h00, 8'h00, 8'h00, 8'h40);
    check("x_rng_err", 32'(err_count_out), 4);
    check("x_rng_pkt", 32'(pkt_count_out), 2);

    // Back-pressure with an overrun byte, then overrun coinciding with handshake
    do_reset();
    wr_ready_in = 1'b0;
    send_pkt(8'h0A, 8'h0B, 8'h0C, 8'h1F, 8'h12);
    idle(5);
    send_byte(8'h55);
    idle(14);
    check("bp_valid", 32'(wr_valid_out), 1);
    check("bp_x", 32'(wr_x_out), 32'h0A);
    check("bp_blk", 32'(wr_block_out), 32'h1F);
    check("bp_err", 32'(err_count_out), 1);
    wr_ready_in = 1'b1;
    tick();
    check("bp_done_valid", 32'(wr_valid_out), 0);
    check("bp_done_pkt", 32'(pkt_count_out), 1);
    wr_ready_in = 1'b0;
    send_pkt(8'h01, 8'h01, 8'h01, 8'h01, 8'h00);
    wr_ready_in = 1'b1;
    send_byte(8'h77);
    check("coin_pkt", 32'(pkt_count_out), 2);
    check("coin_err", 32'(err_count_out), 2);
    check("coin_busy", 32'(busy_out), 0);

    // Idle timeout and error saturation
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(TMO - 1);
    check("tmo_busy_before", 32'(busy_out), 1);
    check("tmo_err_before", 32'(err_count_out), 0);
    tick();
    check("tmo_busy_after", 32'(busy_out), 0);
    check("tmo_err_after", 32'(err_count_out), 1);
    for (int i = 0; i < 300; i++) send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
    check("sat_err", 32'(err_count_out), 255);
    check("sat_pkt", 32'(pkt_count_out), 0);

    // Reset mid-packet after a completed write
    do_reset();
    send_pkt(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    tick();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    do_reset();
    check("mid_x", 32'(wr_x_out), 0);
    check("mid_blk", 32'(wr_block_out), 0);
    send_byte(8'h07);
    send_byte(8'h07);
    idle(3);
    check("mid_valid", 32'(wr_valid_out), 0);
    check("mid_pkt", 32'(pkt_count_out), 0);
    check("mid_busy", 32'(busy_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_block_loader.md
UART_BLOCK_LOADER -- requirements
Module: uart_block_loader

Interface
REQ-001 SHALL have parameter LENGTH, default 64, x extent of the world in blocks.
REQ-002 SHALL have parameter WIDTH, default 64, y extent in blocks.
REQ-003 SHALL have parameter HEIGHT, default 16, z extent in blocks.
REQ-004 SHALL have parameter BLOCK_W, default 5, block-type width in bits.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 10000, maximum idle gap between bytes inside a packet.
REQ-006 SHALL have port clk_in, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port rx_valid_in, input, 1, one-cycle strobe marking a received UART byte.
REQ-009 SHALL have port rx_byte_in, input, 8, received byte, sampled only when rx_valid_in=1.
REQ-010 SHALL have port wr_valid_out, output, 1, block-write request to the L3 cache.
REQ-011 SHALL have port wr_ready_in, input, 1, cache accepts the request this cycle.
REQ-012 SHALL have port wr_x_out, output, $clog2(LENGTH), write x coordinate.
REQ-013 SHALL have port wr_y_out, output, $clog2(WIDTH), write y coordinate.
REQ-014 SHALL have port wr_z_out, output, $clog2(HEIGHT), write z coordinate.
REQ-015 SHALL have port wr_block_out, output, BLOCK_W, block type to write.
REQ-016 SHALL have port busy_out, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port err_count_out, output, 8, count of rejected packets.
REQ-018 SHALL have port pkt_count_out, output, 16, count of completed writes.

Function
REQ-019 SHALL frame packets as six bytes: SYNC=0xA5, X, Y, Z, TYPE, CHK, where CHK = X^Y^Z^TYPE.
REQ-020 SHALL implement the states IDLE, GET_X, GET_Y, GET_Z, GET_T, GET_CHK and EMIT.
REQ-021 SHALL stay in IDLE on non-SYNC bytes, discard them, and leave err_count_out unchanged.
REQ-022 SHALL go from IDLE to GET_X on a 0xA5 byte, then advance one state per accepted byte through GET_CHK.
REQ-023 SHALL treat 0xA5 as data, not as a resync, in every state except IDLE.
REQ-024 SHALL, on the CHK byte, go to EMIT when the checksum matches, X<LENGTH, Y<WIDTH, Z<HEIGHT and TYPE<2^BLOCK_W; otherwise it SHALL go to IDLE and increment err_count_out.
REQ-025 SHALL assert wr_valid_out the cycle after the CHK byte is accepted; the write latency from the CHK strobe is 1 cycle.
REQ-026 SHALL hold wr_x/y/z/block_out stable while wr_valid_out=1; the coordinates are the low bits of X/Y/Z and the block type is TYPE[BLOCK_W-1:0].
REQ-027 SHALL, on wr_valid_out & wr_ready_in, deassert wr_valid_out the next cycle, increment pkt_count_out (wrapping at 2^16) and return to IDLE.
REQ-028 SHALL, for any byte received in EMIT, drop the byte and increment err_count_out (overrun); the pending write SHALL be unaffected.
REQ-029 SHALL count clk_in cycles without rx_valid_in in GET_X..GET_CHK; when the count reaches TIMEOUT_CYCLES, it SHALL go to IDLE and increment err_count_out.
REQ-030 SHALL clear the timeout counter on each accepted byte and on entry to IDLE; EMIT SHALL have no timeout.
REQ-031 SHALL saturate err_count_out at 255.
REQ-032 SHALL apply only one increment when an overrun and a handshake coincide in EMIT: the handshake completes, the byte is dropped, and err_count_out +1.
REQ-033 SHALL update the outputs only from registers; no output is combinational from any input.

Reset
REQ-034 SHALL, while rst_in=0 and asynchronously, force state to IDLE, wr_valid_out=0, wr_x/y/z/block_out=0, busy_out=0, err_count_out=0, pkt_count_out=0 and the timeout counter to 0.
REQ-035 SHALL, on reset asserted mid-packet or in EMIT, discard the partial or pending packet with no write issued; after release it SHALL wait for a new SYNC.

Verification
REQ-036 SHALL pass: bytes A5,03,05,02,07,(03^05^02^07=03) with wr_ready_in=1 -> wr_valid_out high 1 cycle after CHK, x=3, y=5, z=2, block=7, pkt_count_out=1.
REQ-037 SHALL pass: same packet with CHK=0x04 -> no wr_valid_out, err_count_out=1, busy_out=0.
REQ-038 SHALL pass: A5,00,00,10,01,chk (Z=16 >= HEIGHT) -> rejected, err_count_out=1; then a valid packet -> written normally.
REQ-039 SHALL pass: valid packet with wr_ready_in=0 for 20 cycles plus a byte sent meanwhile -> outputs stable, err_count_out=1, and the write completes once wr_ready_in=1.
REQ-040 SHALL pass: A5,01 then silence for TIMEOUT_CYCLES -> IDLE, err_count_out=1; with 300 bad packets err_count_out=255.
REQ-041 SHALL pass: rst_in pulsed low after the GET_Z byte -> all outputs 0 immediately; remaining bytes 07,chk ignored and no write issued.
